// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative single-precision divider.
package fp_div_pkg;

   localparam int unsigned QUOT_BITS = 27;
   localparam int unsigned EXP_W     = 10;
   localparam int unsigned REM_W     = 25;
   localparam int unsigned MANT_W    = 24;
   localparam int unsigned CNT_W     = 5;

   localparam logic [EXP_W-1:0] BIAS      = 10'd127;
   localparam logic [31:0]      CANON_NAN = 32'h7FC0_0000;

   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp_t;

endpackage

// File: rtl/fp_div_round_pack.sv
// Normalize, round-to-nearest-even and pack a raw restoring-division quotient.
module fp_div_round_pack
   import fp_div_pkg::*;
(
   input  logic                    i_sign,
   input  logic signed [EXP_W-1:0] i_exp,
   input  logic [QUOT_BITS-1:0]    i_q,
   input  logic                    i_sticky,
   output logic [31:0]             o_res,
   output logic [4:0]              o_flags
);

   logic [QUOT_BITS-2:0]    w_qn;
   logic signed [EXP_W-1:0] w_exp_n;
   logic signed [EXP_W-1:0] w_exp_r;
   logic                    w_guard;
   logic                    w_rest;
   logic                    w_up;
   logic [MANT_W-1:0]       w_frac;

   // The hidden bit is implicit after normalization, so only the fraction is carried.
   always_comb begin
      w_qn    = i_q[QUOT_BITS-1] ? i_q[QUOT_BITS-2:0] : {i_q[QUOT_BITS-3:0], 1'b0};
      w_exp_n = i_q[QUOT_BITS-1] ? i_exp : i_exp - 10'sd1;
      w_guard = w_qn[2];
      w_rest  = w_qn[1] | w_qn[0] | i_sticky;
      w_up    = w_guard & (w_rest | w_qn[3]);
      w_frac  = {1'b0, w_qn[QUOT_BITS-2:3]} + MANT_W'(w_up);
      w_exp_r = w_frac[MANT_W-1] ? w_exp_n + 10'sd1 : w_exp_n;

      o_flags = '0;
      if (w_exp_r >= 10'sd255) begin
         o_res            = {i_sign, 8'hFF, 23'd0};
         o_flags[FLAG_OF] = 1'b1;
         o_flags[FLAG_NX] = 1'b1;
      end else if (w_exp_r <= 10'sd0) begin
         o_res            = {i_sign, 31'd0};
         o_flags[FLAG_UF] = 1'b1;
         o_flags[FLAG_NX] = 1'b1;
      end else begin
         o_res            = {i_sign, w_exp_r[7:0], w_frac[22:0]};
         o_flags[FLAG_NX] = w_guard | w_rest;
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative restoring FP32 divider, one quotient bit per cycle, valid/ready on both sides.
// FP_DIV_EARLY_EXIT_EN: special-case operands skip the divide loop.
module fp_div_iter
   import fp_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp1_in,
   input  logic [31:0] fp2_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_out,
   output logic [4:0]  flags
);

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_sign;
   logic signed [EXP_W-1:0] r_exp;
   logic [REM_W-1:0]        r_rem;
   logic [MANT_W-1:0]       r_div;
   logic [QUOT_BITS-1:0]    r_q;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_spec;
   logic [31:0]             r_res;
   logic [4:0]              r_res_flags;
   logic                    r_out_valid;
   logic [31:0]             r_fp_out;
   logic [4:0]              r_flags;
   logic                    r_in_ready;

   fp_t                     w_a;
   fp_t                     w_b;
   logic                    w_a_zero, w_a_inf, w_a_nan, w_a_snan;
   logic                    w_b_zero, w_b_inf, w_b_nan, w_b_snan;
   logic                    w_sign;
   logic                    w_spec;
   logic [31:0]             w_spec_res;
   logic [4:0]              w_spec_flags;
   logic signed [EXP_W-1:0] w_exp_in;
   logic [REM_W:0]          w_t;
   logic [31:0]             w_rp_res;
   logic [4:0]              w_rp_flags;

   assign w_a      = fp1_in;
   assign w_b      = fp2_in;
   assign w_sign   = w_a.sign ^ w_b.sign;
   assign w_a_zero = (w_a.exp == 8'h00);
   assign w_b_zero = (w_b.exp == 8'h00);
   assign w_a_inf  = (w_a.exp == 8'hFF) && (w_a.frac == 23'd0);
   assign w_b_inf  = (w_b.exp == 8'hFF) && (w_b.frac == 23'd0);
   assign w_a_nan  = (w_a.exp == 8'hFF) && (w_a.frac != 23'd0);
   assign w_b_nan  = (w_b.exp == 8'hFF) && (w_b.frac != 23'd0);
   assign w_a_snan = w_a_nan && !w_a.frac[22];
   assign w_b_snan = w_b_nan && !w_b.frac[22];
   assign w_exp_in = $signed({2'b00, w_a.exp} - {2'b00, w_b.exp} + BIAS);
   assign w_t      = {1'b0, r_rem} - {2'b00, r_div};

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign fp_out    = r_fp_out;
   assign flags     = r_flags;

   // Special-operand decode; denormals count as zero.
   always_comb begin
      w_spec       = 1'b1;
      w_spec_res   = 32'd0;
      w_spec_flags = 5'd0;
      if (w_a_nan || w_b_nan) begin
         w_spec_res           = CANON_NAN;
         w_spec_flags[FLAG_NV] = w_a_snan | w_b_snan;
      end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_res           = CANON_NAN;
         w_spec_flags[FLAG_NV] = 1'b1;
      end else if (w_a_inf) begin
         w_spec_res = {w_sign, 8'hFF, 23'd0};
      end else if (w_b_inf) begin
         w_spec_res = {w_sign, 31'd0};
      end else if (w_b_zero) begin
         w_spec_res           = {w_sign, 8'hFF, 23'd0};
         w_spec_flags[FLAG_DZ] = 1'b1;
      end else if (w_a_zero) begin
         w_spec_res = {w_sign, 31'd0};
      end else begin
         w_spec = 1'b0;
      end
   end

   fp_div_round_pack u_round_pack (
      .i_sign   (r_sign),
      .i_exp    (r_exp),
      .i_q      (r_q),
      .i_sticky (r_rem != '0),
      .o_res    (w_rp_res),
      .o_flags  (w_rp_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (in_valid) w_next = DIVIDE;
         DIVIDE: begin
`ifdef FP_DIV_EARLY_EXIT_EN
            if (r_spec) w_next = DONE;
            else if (r_cnt == CNT_W'(QUOT_BITS - 1)) w_next = ROUND;
`else
            if (r_cnt == CNT_W'(QUOT_BITS - 1)) w_next = ROUND;
`endif
         end
         ROUND:  w_next = DONE;
         DONE:   if (r_out_valid && out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath; DONE spends its first cycle loading the output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_rem       <= '0;
         r_div       <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_spec      <= 1'b0;
         r_res       <= '0;
         r_res_flags <= '0;
         r_out_valid <= 1'b0;
         r_fp_out    <= '0;
         r_flags     <= '0;
         r_in_ready  <= 1'b1;
      end else begin
         r_in_ready <= (w_next == IDLE);
         case (r_state)
            IDLE: if (in_valid) begin
               r_sign      <= w_sign;
               r_exp       <= w_exp_in;
               r_rem       <= {2'b01, w_a.frac};
               r_div       <= {1'b1, w_b.frac};
               r_q         <= '0;
               r_cnt       <= '0;
               r_spec      <= w_spec;
               r_res       <= w_spec_res;
               r_res_flags <= w_spec_flags;
            end
            DIVIDE: begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_q   <= {r_q[QUOT_BITS-2:0], ~w_t[REM_W]};
               r_rem <= w_t[REM_W] ? {r_rem[REM_W-2:0], 1'b0} : {w_t[REM_W-2:0], 1'b0};
            end
            ROUND: if (!r_spec) begin
               r_res       <= w_rp_res;
               r_res_flags <= w_rp_flags;
            end
            DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_fp_out    <= r_res;
                  r_flags     <= r_res_flags;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed, table-driven bench for fp_div_iter with backpressure and mid-divide reset sequences.
module tb_fp_div_iter;

`ifdef FP_DIV_EARLY_EXIT_EN
   localparam int LAT_SPEC = 2;
`else
   localparam int LAT_SPEC = 29;
`endif
   localparam int LAT_NORM = 29;
   localparam int NVEC     = 19;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  fl;
      logic        spec;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] fp1_in = '0;
   logic [31:0] fp2_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] fp_out;
   logic [4:0]  flags;

   int   checks = 0;
   int   failures = 0;
   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   fp_div_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fp1_in    (fp1_in),
      .fp2_in    (fp2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_out    (fp_out),
      .flags     (flags)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      fp1_in   = a;
      fp2_in   = b;
      in_valid = 1'b1;
      chk("in_ready_at_issue", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic retire();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("out_valid_after_retire", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int   lat;
      logic seen;

      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b0};
      vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1'b1};
      vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b1};
      vecs[4]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'b00101, 1'b0};
      vecs[5]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 5'b00011, 1'b0};
      vecs[6]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 1'b0};
      vecs[7]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1'b1};
      vecs[8]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'b10000, 1'b1};
      vecs[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 1'b1};
      vecs[10] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 1'b1};
      vecs[11] = '{32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000, 1'b1};
      vecs[12] = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 5'b00000, 1'b1};
      vecs[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000, 1'b1};
      vecs[14] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800000, 5'b00000, 1'b0};
      vecs[15] = '{32'h40400000, 32'h3FC00000, 32'h40000000, 5'b00000, 1'b0};
      vecs[16] = '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 1'b1};
      vecs[17] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 5'b01000, 1'b1};
      vecs[18] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fp_out", fp_out, 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_valid(lat);
         chk($sformatf("latency[%0d]", i), 32'(lat), vecs[i].spec ? 32'(LAT_SPEC) : 32'(LAT_NORM));
         chk($sformatf("result[%0d]", i), fp_out, vecs[i].res);
         chk($sformatf("flags[%0d]", i), 32'(flags), 32'(vecs[i].fl));
         retire();
      end

      // Backpressure, then retire together with a new request
      start_op(32'h40C00000, 32'h40000000);
      wait_valid(lat);
      chk("bp_latency", 32'(lat), 32'(LAT_NORM));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp_valid[%0d]", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp_result[%0d]", k), fp_out, 32'h40400000);
         chk($sformatf("bp_flags[%0d]", k), 32'(flags), 32'd0);
         chk($sformatf("bp_in_ready[%0d]", k), 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      fp1_in    = 32'h3F800000;
      fp2_in    = 32'h40400000;
      @(posedge clk);
      #1;
      chk("overlap_out_valid", 32'(out_valid), 32'd0);
      chk("overlap_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("overlap_accepted", 32'(in_ready), 32'd0);
      wait_valid(lat);
      chk("overlap_latency", 32'(lat), 32'(LAT_NORM));
      chk("overlap_result", fp_out, 32'h3EAAAAAB);
      chk("overlap_flags", 32'(flags), 32'd1);
      retire();

      // Reset in the middle of a divide
      start_op(32'h40C00000, 32'h40000000);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_fp_out", fp_out, 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 seen = seen | out_valid;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
      chk("abort_ready_after", 32'(in_ready), 32'd1);
      start_op(32'h40400000, 32'h3FC00000);
      wait_valid(lat);
      chk("post_abort_latency", 32'(lat), 32'(LAT_NORM));
      chk("post_abort_result", fp_out, 32'h40000000);
      chk("post_abort_flags", 32'(flags), 32'd0);
      retire();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
